// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through FIFO that queues ALU results
// (result, carry-out, select) for a downstream consumer.
//
// Optional feature macro: ALU_RESULT_FLAGS_EN
//   defined   -> zero/neg flags are computed at push and stored per entry
//   undefined -> no flag storage; out_zero/out_neg are tied low
//
// Handshake: a push happens on a rising edge when in_valid & in_ready; a pop
// happens on the same edge when out_valid & out_ready. in_ready depends only
// on occupancy (never on out_ready), and out_valid depends only on occupancy,
// so there is no combinational path from any input to any output.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_result,
    input  logic                     in_carry,
    input  logic [1:0]               in_select,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_carry,
    output logic [1:0]               out_select,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_err,
    input  logic                     clr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic [WIDTH-1:0] result_mem [DEPTH];
    logic             carry_mem  [DEPTH];
    logic [1:0]       select_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;
    logic          head_zero;
    logic          head_neg;

    // Handshake qualification from occupancy only
    always_comb begin
        in_ready  = (count_q < FULL_COUNT);
        out_valid = (count_q != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // Entry storage; not reset because reset discards entries via the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            result_mem[wr_ptr] <= in_result;
            carry_mem[wr_ptr]  <= in_carry;
            select_mem[wr_ptr] <= in_select;
        end
    end

`ifdef ALU_RESULT_FLAGS_EN
    logic zero_mem [DEPTH];
    logic neg_mem  [DEPTH];

    // Flags are derived once at push time and stored alongside the entry
    always_ff @(posedge clk) begin
        if (push) begin
            zero_mem[wr_ptr] <= (in_result == '0);
            neg_mem[wr_ptr]  <= in_result[WIDTH-1];
        end
    end

    // Head flags read straight from the read pointer
    always_comb begin
        head_zero = zero_mem[rd_ptr];
        head_neg  = neg_mem[rd_ptr];
    end
`else
    // Flag feature absent: head flags are constant zero
    always_comb begin
        head_zero = 1'b0;
        head_neg  = 1'b0;
    end
`endif

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky refused-push flag; a drop in the same cycle beats the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err <= 1'b0;
        end else if (in_valid && !in_ready) begin
            drop_err <= 1'b1;
        end else if (clr_err) begin
            drop_err <= 1'b0;
        end
    end

    // Head fields fall through from the read pointer, forced to zero when empty
    always_comb begin
        count      = count_q;
        out_result = '0;
        out_carry  = 1'b0;
        out_select = 2'b00;
        out_zero   = 1'b0;
        out_neg    = 1'b0;
        if (out_valid) begin
            out_result = result_mem[rd_ptr];
            out_carry  = carry_mem[rd_ptr];
            out_select = select_mem[rd_ptr];
            out_zero   = head_zero;
            out_neg    = head_neg;
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Testbench for alu_result_fifo: table-driven directed vectors plus a queue
// scoreboard of expected entries, hand-written reset/flag sequences and a
// random push/pop phase.
module tb_alu_result_fifo;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int EW    = WIDTH + 3;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_result;
  logic             in_carry;
  logic [1:0]       in_select;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic [1:0]       out_select;
  logic             out_zero;
  logic             out_neg;
  logic [2:0]       count;
  logic             drop_err;
  logic             clr_err;

  alu_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_result  (in_result),
    .in_carry   (in_carry),
    .in_select  (in_select),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_select (out_select),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .count      (count),
    .drop_err   (drop_err),
    .clr_err    (clr_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=done");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];   // {carry, select, result}
  logic          m_drop;
  int            checks;
  int            errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_flags(input logic [WIDTH-1:0] r);
`ifdef ALU_RESULT_FLAGS_EN
    return {(r == '0), r[WIDTH-1]};
`else
    return 2'b00;
`endif
  endfunction

  task automatic check_head(input string tag, input logic [EW-1:0] e);
    check({tag, "_result"}, 64'(out_result), 64'(e[WIDTH-1:0]));
    check({tag, "_carry"},  64'(out_carry),  64'(e[EW-1]));
    check({tag, "_select"}, 64'(out_select), 64'(e[WIDTH+1:WIDTH]));
    check({tag, "_flags"},  64'({out_zero, out_neg}), 64'(exp_flags(e[WIDTH-1:0])));
  endtask

  // Post-edge state comparison against the scoreboard model
  task automatic check_state();
    check("count", 64'(count), 64'(exp_q.size()));
    check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
    check("drop_err", 64'(drop_err), 64'(m_drop));
    if (exp_q.size() == 0)
      check("empty_fields", 64'({out_result, out_carry, out_select, out_zero, out_neg}), 64'(0));
    else
      check_head("head", exp_q[0]);
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; drives one cycle and checks the result.
  task automatic step(input logic v, input logic [WIDTH-1:0] r, input logic c,
                      input logic [1:0] s, input logic rdy, input logic clr);
    logic          model_ready;
    logic [EW-1:0] head;
    in_valid  = v;
    in_result = r;
    in_carry  = c;
    in_select = s;
    out_ready = rdy;
    clr_err   = clr;
    #1;
    model_ready = (exp_q.size() < DEPTH);
    check("in_ready", 64'(in_ready), 64'(model_ready));
    if (rdy && exp_q.size() > 0) begin
      head = exp_q.pop_front();
      check_head("pop", head);
    end
    if (v && model_ready) exp_q.push_back({c, s, r});
    if (v && !model_ready) m_drop = 1'b1;
    else if (clr)          m_drop = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_state();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_drop = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_drop_err", 64'(drop_err), 64'(0));
    check("rst_fields", 64'({out_result, out_carry, out_select, out_zero, out_neg}), 64'(0));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic             v;
    logic [WIDTH-1:0] r;
    logic             c;
    logic [1:0]       s;
    logic             rdy;
    logic             clr;
    logic [2:0]       e_count;
    logic             e_in_ready;
    logic             e_out_valid;
    logic             e_drop;
  } vec_t;

  vec_t vecs[15];

  initial begin
    checks    = 0;
    errors    = 0;
    m_drop    = 1'b0;
    in_valid  = 1'b0;
    in_result = '0;
    in_carry  = 1'b0;
    in_select = 2'b00;
    out_ready = 1'b0;
    clr_err   = 1'b0;

    //          v   result        c  sel   rdy clr  cnt rdy vld drop
    vecs[0]  = '{1, 32'h0000458D, 0, 2'b01, 0, 0,   1,  1,  1,  0};  // single push
    vecs[1]  = '{0, 32'h0,        0, 2'b00, 1, 0,   0,  1,  0,  0};  // pop back to empty
    vecs[2]  = '{1, 32'h1,        1, 2'b10, 0, 0,   1,  1,  1,  0};
    vecs[3]  = '{1, 32'h2,        0, 2'b11, 0, 0,   2,  1,  1,  0};
    vecs[4]  = '{1, 32'h3,        1, 2'b00, 0, 0,   3,  1,  1,  0};
    vecs[5]  = '{1, 32'h4,        0, 2'b01, 0, 0,   4,  0,  1,  0};  // full
    vecs[6]  = '{1, 32'h5,        0, 2'b00, 0, 0,   4,  0,  1,  1};  // refused push
    vecs[7]  = '{0, 32'h0,        0, 2'b00, 0, 1,   4,  0,  1,  0};  // clear, no drop
    vecs[8]  = '{1, 32'h6,        0, 2'b00, 0, 1,   4,  0,  1,  1};  // drop beats clear
    vecs[9]  = '{1, 32'h7,        0, 2'b00, 1, 0,   3,  1,  1,  1};  // pop at full, push refused
    vecs[10] = '{0, 32'h0,        0, 2'b00, 1, 0,   2,  1,  1,  1};
    vecs[11] = '{0, 32'h0,        0, 2'b00, 1, 0,   1,  1,  1,  1};
    vecs[12] = '{0, 32'h0,        0, 2'b00, 1, 0,   0,  1,  0,  1};
    vecs[13] = '{0, 32'h0,        0, 2'b00, 1, 1,   0,  1,  0,  0};  // pop on empty ignored
    vecs[14] = '{1, 32'hA,        0, 2'b10, 0, 0,   1,  1,  1,  0};

    // Reset with no clock edge yet
    reset_now();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_state();

    // Table-driven directed vectors
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].v, vecs[i].r, vecs[i].c, vecs[i].s, vecs[i].rdy, vecs[i].clr);
      check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_count));
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_in_ready));
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_out_valid));
      check($sformatf("vec%0d_drop_err", i), 64'(drop_err), 64'(vecs[i].e_drop));
    end

    // Simultaneous push/pop at count 2
    step(1, 32'hB, 1, 2'b11, 0, 0);
    check("pre_sim_count", 64'(count), 64'(2));
    step(1, 32'hFFFFFFFF, 1, 2'b01, 1, 0);
    check("sim_count", 64'(count), 64'(2));
    for (int i = 0; i < 8; i++)
      step($urandom_range(0, 1), $urandom, $urandom_range(0, 1), 2'($urandom_range(0, 3)),
           $urandom_range(0, 1), 0);

    // Flag sequence from empty
    while (exp_q.size() > 0) step(0, 0, 0, 0, 1, 0);
    step(1, 32'h00000000, 0, 2'b00, 0, 0);
    check("flag0_zero", 64'(out_zero), 64'(exp_flags(32'h00000000) >> 1));
    check("flag0_neg", 64'(out_neg), 64'(exp_flags(32'h00000000) & 2'b01));
    step(1, 32'h80000000, 0, 2'b00, 1, 0);
    check("flag1_zero", 64'(out_zero), 64'(exp_flags(32'h80000000) >> 1));
    check("flag1_neg", 64'(out_neg), 64'(exp_flags(32'h80000000) & 2'b01));

    // Random mixed traffic, biased toward full to exercise refusals and wrap
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1), 2'($urandom_range(0, 3)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);

    // Reset mid-operation discards stored entries
    step(1, 32'h1234, 0, 2'b10, 0, 0);
    #2;
    reset_now();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_state();
    step(1, 32'h55AA, 1, 2'b11, 0, 0);
    step(0, 0, 0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
